// File: rtl/captura_datos_rtc_pkg.sv
// captura_datos_rtc_pkg: field indices, RTC addressing defaults and FSM encoding for the RTC read path
package captura_datos_rtc_pkg;
    localparam logic [3:0] CAMPO_SEG = 4'd0;
    localparam logic [3:0] CAMPO_MIN = 4'd1;
    localparam logic [3:0] CAMPO_HOUR = 4'd2;
    localparam logic [3:0] CAMPO_DIA = 4'd3;
    localparam logic [3:0] CAMPO_MES = 4'd4;
    localparam logic [3:0] CAMPO_ANO = 4'd5;
    localparam logic [7:0] DIR_BASE_DEF = 8'h21;
    localparam int N_CAMPOS_DEF = 6;
    localparam logic [7:0] TIMEOUT_DEF = 8'd255;
    typedef enum logic [2:0] {IDLE, REQ, WAIT, STORE, DONE} estado_t;
endpackage

// File: rtl/captura_datos_rtc_verif_bcd.sv
// captura_datos_rtc_verif_bcd: flags a byte whose either nibble is not a BCD digit
module captura_datos_rtc_verif_bcd (
    input  logic [7:0] dato,
    output logic       invalido
);
    assign invalido = (dato[7:4] > 4'd9) || (dato[3:0] > 4'd9);
endmodule

// File: rtl/captura_datos_rtc.sv
// captura_datos_rtc: reads the six RTC time/date registers one byte at a time into shadows
// and publishes them together as one coherent snapshot
module captura_datos_rtc
    import captura_datos_rtc_pkg::*;
#(
    parameter logic [7:0] DIR_BASE = DIR_BASE_DEF,
    parameter int         N_CAMPOS = N_CAMPOS_DEF,
    parameter logic [7:0] TIMEOUT = TIMEOUT_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       rd_ack,
    input  logic [7:0] dato_rtc,
    output logic       rd_req,
    output logic [7:0] dir_rtc,
    output logic [3:0] band,
    output logic [7:0] out_seg,
    output logic [7:0] out_min,
    output logic [7:0] out_hour,
    output logic [7:0] out_dia,
    output logic [7:0] out_mes,
    output logic [7:0] out_ano,
    output logic       datos_listo,
    output logic       ocupado,
    output logic       err_timeout,
    output logic       err_bcd
);
    estado_t estado;
    logic [3:0] idx;
    logic [7:0] timer;
    logic [N_CAMPOS-1:0][7:0] sombra;
    logic bcd_inv;
    logic [3:0] idx_sig;

    captura_datos_rtc_verif_bcd u_verif_bcd (.dato(dato_rtc), .invalido(bcd_inv));

    assign idx_sig = idx + 4'd1;
    assign ocupado = estado != IDLE;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado <= IDLE;
            idx <= '0;
            timer <= '0;
            sombra <= '0;
            rd_req <= 1'b0;
            dir_rtc <= '0;
            band <= '0;
            out_seg <= '0;
            out_min <= '0;
            out_hour <= '0;
            out_dia <= '0;
            out_mes <= '0;
            out_ano <= '0;
            datos_listo <= 1'b0;
            err_timeout <= 1'b0;
            err_bcd <= 1'b0;
        end else begin
            case (estado)
                IDLE: if (start) begin
                    estado <= REQ;
                    idx <= CAMPO_SEG;
                    rd_req <= 1'b1;
                    dir_rtc <= DIR_BASE + {4'd0, CAMPO_SEG};
                    band <= CAMPO_SEG;
                    err_timeout <= 1'b0;
                    err_bcd <= 1'b0;
                end
                REQ: begin
                    rd_req <= 1'b0;
                    timer <= '0;
                    estado <= WAIT;
                end
                // an ack arriving on the last allowed cycle still completes the read
                WAIT: if (rd_ack) begin
                    sombra[idx[2:0]] <= dato_rtc;
                    err_bcd <= err_bcd | bcd_inv;
                    estado <= STORE;
                end else if (timer == TIMEOUT) begin
                    err_timeout <= 1'b1;
                    estado <= IDLE;
                end else begin
                    timer <= timer + {7'd0, timer != 8'hFF};
                end
                STORE: if (idx == 4'(N_CAMPOS - 1)) begin
                    out_seg <= sombra[CAMPO_SEG[2:0]];
                    out_min <= sombra[CAMPO_MIN[2:0]];
                    out_hour <= sombra[CAMPO_HOUR[2:0]];
                    out_dia <= sombra[CAMPO_DIA[2:0]];
                    out_mes <= sombra[CAMPO_MES[2:0]];
                    out_ano <= sombra[CAMPO_ANO[2:0]];
                    datos_listo <= 1'b1;
                    estado <= DONE;
                end else begin
                    idx <= idx_sig;
                    rd_req <= 1'b1;
                    dir_rtc <= DIR_BASE + {4'd0, idx_sig};
                    band <= idx_sig;
                    estado <= REQ;
                end
                DONE: begin
                    datos_listo <= 1'b0;
                    estado <= IDLE;
                end
                default: estado <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_captura_datos_rtc.sv
// tb_captura_datos_rtc: directed scenarios; a bus responder checks addresses, a monitor
// pops expected snapshots whenever datos_listo pulses
module tb_captura_datos_rtc;
    logic clk = 0, reset = 0, start = 0, ack_resp = 0, ack_main = 0, rd_ack;
    logic [7:0] dato_rtc = 0;
    logic rd_req, datos_listo, ocupado, err_timeout, err_bcd;
    logic [7:0] dir_rtc, out_seg, out_min, out_hour, out_dia, out_mes, out_ano;
    logic [3:0] band;
    logic [47:0] outs, prev_outs = 0, vals = 0;

    typedef struct packed {
        logic [47:0] v;
        logic        bcd;
        logic [15:0] lat;
    } snap_t;

    snap_t exp_snap[$];
    logic [11:0] exp_dir[$];
    int dly[6];
    int checks = 0, errors = 0, cyc = 0, start_cyc = 0, n_listo = 0, n0 = 0;

    assign rd_ack = ack_resp | ack_main;
    assign outs = {out_ano, out_mes, out_dia, out_hour, out_min, out_seg};

    captura_datos_rtc dut (
        .clk(clk), .reset(reset), .start(start), .rd_ack(rd_ack), .dato_rtc(dato_rtc),
        .rd_req(rd_req), .dir_rtc(dir_rtc), .band(band),
        .out_seg(out_seg), .out_min(out_min), .out_hour(out_hour),
        .out_dia(out_dia), .out_mes(out_mes), .out_ano(out_ano),
        .datos_listo(datos_listo), .ocupado(ocupado),
        .err_timeout(err_timeout), .err_bcd(err_bcd)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic go(input int nf, input bit pub, input bit bcd, input int lat);
        for (int i = 0; i < nf; i++) exp_dir.push_back({4'(i), 8'(8'h21 + i)});
        if (pub) exp_snap.push_back({vals, bcd, 16'(lat)});
        @(negedge clk);
        start = 1;
        @(posedge clk);
        #1 start_cyc = cyc;
        start = 0;
        @(negedge clk);
        chk("err_clear_on_start", {err_timeout, err_bcd}, 0);
        chk("busy_after_start", ocupado, 1);
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ocupado && n < bound);
        if (ocupado) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: still busy after %0d cycles", bound);
        end
    endtask

    // bus responder: checks each request, then acks after the configured delay (-1 = never)
    initial forever begin
        @(negedge clk);
        if (reset && rd_req) begin
            automatic int f = int'(band);
            automatic logic [11:0] e = 0;
            automatic bit have = exp_dir.size() != 0;
            if (!have) begin
                checks++;
                errors++;
                $display("FAIL rd_req: unexpected request dir %h band %h", dir_rtc, band);
            end else begin
                e = exp_dir.pop_front();
                chk("band_dir", {band, dir_rtc}, e);
            end
            if (f < 6 && dly[f] >= 0) begin
                repeat (dly[f]) @(negedge clk);
                @(negedge clk);
                chk("rd_req_one_cycle", rd_req, 0);
                if (have) chk("dir_held", dir_rtc, e[7:0]);
                ack_resp = 1;
                dato_rtc = vals[f*8 +: 8];
                @(negedge clk);
                ack_resp = 0;
            end
        end
    end

    // snapshot monitor and output stability watch
    initial forever begin
        @(negedge clk);
        if (reset && datos_listo) begin
            automatic snap_t s;
            n_listo++;
            if (exp_snap.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL datos_listo: unexpected pulse, outs %h", outs);
            end else begin
                s = exp_snap.pop_front();
                chk("snapshot", outs, s.v);
                chk("err_bcd", err_bcd, s.bcd);
                chk("err_timeout", err_timeout, 0);
                chk("latency", cyc - start_cyc, s.lat);
            end
        end else if (reset) begin
            chk("out_stable", outs, prev_outs);
        end
        prev_outs = outs;
    end

    initial begin
        for (int i = 0; i < 6; i++) dly[i] = 0;
        repeat (3) @(negedge clk);
        chk("reset_outs", outs, 0);
        chk("reset_ctl", {rd_req, dir_rtc, band, datos_listo, ocupado, err_timeout, err_bcd}, 0);
        reset = 1;
        ack_main = 1;
        repeat (5) @(negedge clk);
        ack_main = 0;
        repeat (3) @(negedge clk);
        chk("idle_outs", outs, 0);
        chk("idle_ctl", {rd_req, dir_rtc, band, datos_listo, ocupado, err_timeout, err_bcd}, 0);

        vals = 48'h16_09_07_12_30_45;
        go(6, 1, 0, 18);
        wait_idle(400);

        vals = 48'h99_12_31_23_59_59;
        dly[2] = 10;
        go(6, 1, 0, 28);
        wait_idle(400);
        dly[2] = 0;

        vals = 48'h25_06_15_08_10_05;
        dly[1] = 255;
        go(6, 1, 0, 273);
        wait_idle(600);
        chk("ack_beats_timeout", err_timeout, 0);
        dly[1] = 0;

        vals = 48'h11_11_11_11_11_11;
        dly[3] = -1;
        go(4, 0, 0, 0);
        wait_idle(600);
        chk("abort_cycles", cyc - start_cyc, 266);
        chk("timeout_flag", err_timeout, 1);
        chk("abort_idle", {ocupado, rd_req, datos_listo}, 0);
        chk("abort_keeps_outs", outs, 48'h25_06_15_08_10_05);
        dly[3] = 0;
        repeat (3) @(negedge clk);

        vals = 48'h24_01_01_00_00_5A;
        n0 = n_listo;
        go(6, 1, 1, 18);
        repeat (4) @(negedge clk);
        start = 1;
        @(negedge clk);
        start = 0;
        wait_idle(400);
        repeat (5) @(negedge clk);
        chk("single_listo", n_listo - n0, 1);
        chk("err_bcd_sticky", err_bcd, 1);

        vals = 48'h23_11_28_14_45_33;
        dly[4] = -1;
        go(5, 0, 0, 0);
        for (int i = 0; i < 40 && !(band == 4'd4 && ocupado && !rd_req); i++) @(negedge clk);
        chk("in_wait_field4", {band, ocupado, rd_req}, {4'd4, 1'b1, 1'b0});
        #2 reset = 0;
        #1;
        chk("async_reset_outs", outs, 0);
        chk("async_reset_ctl", {rd_req, dir_rtc, band, datos_listo, ocupado, err_timeout, err_bcd}, 0);
        exp_dir.delete();
        exp_snap.delete();
        @(negedge clk);
        reset = 1;
        dly[4] = 0;
        vals = 48'h23_11_28_14_45_34;
        go(6, 1, 0, 18);
        wait_idle(400);
        repeat (3) @(negedge clk);
        chk("queues_drained", {16'(exp_snap.size()), 16'(exp_dir.size())}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
